rx_frame_chk: RTL

RX_FRAME_CHK -- requirements
Module: rx_frame_chk

---
 rtl/rx_frame_chk_pkg.sv | 16 +
 rtl/rx_par_calc.sv | 18 +
 rtl/rx_frame_chk.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/rx_frame_chk_pkg.sv
// Shared definitions for the receive frame checker: state encoding and
// default widths used by the top level and its parity helper.
package rx_frame_chk_pkg;

  localparam int RX_DATA_W_DEF = 8;
  localparam int RX_CNT_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DATA   = 3'd1,
    ST_PARITY = 3'd2,
    ST_STOP1  = 3'd3,
    ST_STOP2  = 3'd4
  } rx_state_e;

endpackage

// File: rtl/rx_par_calc.sv
// Combinational parity generator: produces the parity bit a transmitter
// would append to i_data for the selected odd/even sense.
module rx_par_calc
  import rx_frame_chk_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_odd,
  output logic              o_par
);

  // Odd sense inverts the plain XOR so that data plus parity has odd weight.
  always_comb begin
    o_par = (^i_data) ^ i_odd;
  end

endmodule

// File: rtl/rx_frame_chk.sv
// UART-style receive frame checker. Assembles DATA_W data bits from
// pre-sampled strobes, checks optional parity and one or two stop bits,
// reports each completed frame and keeps a saturating errored-frame count.
module rx_frame_chk
  import rx_frame_chk_pkg::*;
#(
  parameter int DATA_W = RX_DATA_W_DEF,
  parameter int CNT_W  = RX_CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_bit_valid,
  input  logic              i_sampled_bit,
  input  logic              i_par_en,
  input  logic              i_par_odd,
  input  logic              i_two_stop,
  input  logic              i_err_clr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_data_valid,
  output logic              o_par_err,
  output logic              o_stp_err,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam int BC_W = $clog2(DATA_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  rx_state_e         state_q;
  logic [BC_W-1:0]   bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] data_q;
  logic              par_en_q;
  logic              par_odd_q;
  logic              two_stop_q;
  logic              par_acc_q;
  logic              stp_acc_q;
  logic              dv_q;
  logic              par_err_q;
  logic              stp_err_q;
  logic              busy_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_cnt_d;

  logic              par_exp;
  logic              stop_bad;
  logic              frame_done;
  logic              frame_err;

  // Expected parity bit for the assembled data under the latched sense.
  rx_par_calc #(
    .DATA_W (DATA_W)
  ) u_par_calc (
    .i_data (shift_q),
    .i_odd  (par_odd_q),
    .o_par  (par_exp)
  );

  // Detect the final stop strobe (a restart in the same cycle wins) and
  // form the next error-count value; clear beats a same-cycle increment.
  always_comb begin
    stop_bad   = ~i_sampled_bit;
    frame_done = i_bit_valid & ~i_start &
                 ((state_q == ST_STOP2) | ((state_q == ST_STOP1) & ~two_stop_q));
    frame_err  = par_acc_q | stp_acc_q | stop_bad;
    err_cnt_d  = err_cnt_q;
    if (i_err_clr) begin
      err_cnt_d = '0;
    end else if (frame_done && frame_err && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // Frame sequencing FSM with registered frame outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      par_acc_q  <= 1'b0;
      stp_acc_q  <= 1'b0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      dv_q <= 1'b0;
      if (i_start) begin
        // A start always restarts framing, abandoning any partial frame.
        state_q    <= ST_DATA;
        busy_q     <= 1'b1;
        bit_cnt_q  <= '0;
        shift_q    <= '0;
        par_acc_q  <= 1'b0;
        stp_acc_q  <= 1'b0;
        par_en_q   <= i_par_en;
        par_odd_q  <= i_par_odd;
        two_stop_q <= i_two_stop;
      end else if (i_bit_valid) begin
        unique case (state_q)
          ST_IDLE: begin
          end
          ST_DATA: begin
            shift_q <= {i_sampled_bit, shift_q[DATA_W-1:1]};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
              state_q   <= par_en_q ? ST_PARITY : ST_STOP1;
            end else begin
              bit_cnt_q <= bit_cnt_q + BC_W'(1);
            end
          end
          ST_PARITY: begin
            par_acc_q <= (i_sampled_bit != par_exp);
            state_q   <= ST_STOP1;
          end
          ST_STOP1: begin
            if (two_stop_q) begin
              stp_acc_q <= stop_bad;
              state_q   <= ST_STOP2;
            end else begin
              state_q   <= ST_IDLE;
              busy_q    <= 1'b0;
              dv_q      <= 1'b1;
              data_q    <= shift_q;
              par_err_q <= par_acc_q & par_en_q;
              stp_err_q <= stp_acc_q | stop_bad;
            end
          end
          ST_STOP2: begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            dv_q      <= 1'b1;
            data_q    <= shift_q;
            par_err_q <= par_acc_q & par_en_q;
            stp_err_q <= stp_acc_q | stop_bad;
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Errored-frame counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_data       = data_q;
  assign o_data_valid = dv_q;
  assign o_par_err    = par_err_q;
  assign o_stp_err    = stp_err_q;
  assign o_busy       = busy_q;
  assign o_err_cnt    = err_cnt_q;

endmodule
